// File: rtl/mem_port_arbiter.sv
// Purpose : hands a single memory write port between the processor and a comm loader.
// Latency : exactly one clk from cpu_*/com_* to mem_*; every output is a flop.
// Backpress: cpu_stall holds the processor while the loader owns the port or a handover is in flight.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_we/cpu_addr/cpu_wdata        processor write request (used only in CPU_OWN)
//   cpu_ack                          processor has reached a safe stall point
//   cpu_stall                        hold request to the processor
//   com_req                          loader ownership request (level)
//   com_we/com_addr/com_wdata        loader write request (used only in COM_OWN)
//   com_gnt                          loader currently owns the port
//   mem_we/mem_addr/mem_wdata        registered memory write port
//   wr_count                         loader writes accepted in the current/last ownership (saturating)
//   timeout_flag                     sticky, last ownership was ended by the idle timeout
module mem_port_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              com_req,
    input  logic              com_we,
    input  logic [ADDR_W-1:0] com_addr,
    input  logic [DATA_W-1:0] com_wdata,
    output logic              com_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  wr_count,
    output logic              timeout_flag
);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        DRAIN   = 2'd1,
        COM_OWN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Idle counter only has to reach TIMEOUT-1.
    localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;
    localparam logic              TO_EN     = (TIMEOUT > 0);

    state_t              r_state;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_stall;
    logic                r_com_gnt;
    logic [CNT_W-1:0]    r_wr_count;
    logic                r_timeout_flag;
    logic [IDLE_W-1:0]   r_idle;

    logic                w_timeout_hit;
    logic                w_cnt_max;

    // A write cycle is never idle, so it can never trigger the timeout.
    assign w_timeout_hit = TO_EN && !com_we && (r_idle == IDLE_LAST);
    assign w_cnt_max     = (r_wr_count == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= CPU_OWN;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_cpu_stall    <= 1'b0;
            r_com_gnt      <= 1'b0;
            r_wr_count     <= '0;
            r_timeout_flag <= 1'b0;
            r_idle         <= '0;
        end else begin
            case (r_state)
                CPU_OWN: begin
                    r_mem_we    <= cpu_we;
                    r_mem_addr  <= cpu_addr;
                    r_mem_wdata <= cpu_wdata;
                    if (com_req) begin
                        r_state     <= DRAIN;
                        r_cpu_stall <= 1'b1;
                    end
                end

                DRAIN: begin
                    r_mem_we <= 1'b0;
                    // Withdrawal wins over a simultaneous ack.
                    if (!com_req) begin
                        r_state     <= CPU_OWN;
                        r_cpu_stall <= 1'b0;
                    end else if (cpu_ack) begin
                        r_state        <= COM_OWN;
                        r_com_gnt      <= 1'b1;
                        r_wr_count     <= '0;
                        r_timeout_flag <= 1'b0;
                        r_idle         <= '0;
                    end
                end

                COM_OWN: begin
                    // The write in the cycle com_req drops is still taken.
                    r_mem_we    <= com_we;
                    r_mem_addr  <= com_addr;
                    r_mem_wdata <= com_wdata;
                    if (com_we) begin
                        r_idle <= '0;
                        if (!w_cnt_max) begin
                            r_wr_count <= r_wr_count + CNT_W'(1);
                        end
                    end else if (TO_EN && !w_timeout_hit) begin
                        r_idle <= r_idle + IDLE_W'(1);
                    end

                    if (!com_req) begin
                        r_state   <= RELEASE;
                        r_com_gnt <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_state        <= RELEASE;
                        r_com_gnt      <= 1'b0;
                        r_timeout_flag <= 1'b1;
                    end
                end

                RELEASE: begin
                    // One dead cycle so the loader's last write settles before the processor resumes.
                    r_mem_we    <= 1'b0;
                    r_com_gnt   <= 1'b0;
                    r_cpu_stall <= 1'b0;
                    r_state     <= CPU_OWN;
                end

                default: begin
                    r_state     <= CPU_OWN;
                    r_mem_we    <= 1'b0;
                    r_com_gnt   <= 1'b0;
                    r_cpu_stall <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_stall    = r_cpu_stall;
    assign com_gnt      = r_com_gnt;
    assign wr_count     = r_wr_count;
    assign timeout_flag = r_timeout_flag;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 16, data bus width.
REQ-002 SHALL have parameter ADDR_W, 16, address bus width.
REQ-003 SHALL have parameter CNT_W, 16, width of the comm-write counter.
REQ-004 SHALL have parameter TIMEOUT, 1024, idle cycles in COM_OWN before forced release; 0 disables the timeout.
REQ-005 SHALL use one clock and an asynchronous, active-low reset:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  cpu_we  in  1  processor write enable
  cpu_addr  in  ADDR_W  processor address
  cpu_wdata  in  DATA_W  processor write data
  cpu_ack  in  1  processor reached a safe stall point
  cpu_stall  out  1  processor hold request
  com_req  in  1  comm loader requests memory ownership (level)
  com_we  in  1  comm write strobe, one write per high cycle
  com_addr  in  ADDR_W  comm address
  com_wdata  in  DATA_W  comm write data
  com_gnt  out  1  comm owns the memory port
  mem_we  out  1  registered memory write enable
  mem_addr  out  ADDR_W  registered memory address
  mem_wdata  out  DATA_W  registered memory write data
  wr_count  out  CNT_W  comm writes accepted in the current ownership
  timeout_flag  out  1  sticky: last ownership ended by timeout

Function
REQ-006 SHALL implement states CPU_OWN, DRAIN, COM_OWN, RELEASE.
REQ-007 CPU_OWN: mem_* register cpu_* each cycle; com_req=1 -> DRAIN, cpu_stall=1 from next cycle.
REQ-008 DRAIN: mem_we registered 0; cpu_ack=1 -> COM_OWN, com_gnt=1 from next cycle; com_req=0 -> CPU_OWN, cpu_stall=0 next cycle, com_gnt never asserted.
REQ-009 DRAIN with cpu_ack=1 and com_req=0 in the same cycle SHALL go to CPU_OWN (withdrawal wins).
REQ-010 COM_OWN: mem_we/mem_addr/mem_wdata register com_we/com_addr/com_wdata; cpu_stall=1, com_gnt=1.
REQ-011 COM_OWN: com_req=0 -> RELEASE; com_we in that same cycle SHALL still be registered and counted.
REQ-012 COM_OWN: idle counter clears on each com_we=1 cycle, increments otherwise; reaching TIMEOUT-1 -> RELEASE and timeout_flag=1 (TIMEOUT>0 only).
REQ-013 RELEASE: one cycle; mem_we registered 0, com_gnt=0, cpu_stall=1; then CPU_OWN, cpu_stall=0.
REQ-014 From RELEASE, if com_req is still 1 in CPU_OWN, the FSM SHALL re-enter DRAIN normally.
REQ-015 Output latency SHALL be exactly one clk from source inputs to mem_*; no combinational input-to-mem_* path.
REQ-016 wr_count SHALL clear on DRAIN->COM_OWN, increment per accepted com_we, saturate at 2^CNT_W-1, hold its value after release.
REQ-017 timeout_flag SHALL clear on the next DRAIN->COM_OWN transition.
REQ-018 com_we outside COM_OWN and cpu_we outside CPU_OWN SHALL be ignored.

Reset
REQ-019 rst_n=0 SHALL asynchronously force CPU_OWN, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, com_gnt=0, wr_count=0, timeout_flag=0, idle counter=0.
REQ-020 Reset during COM_OWN SHALL abort ownership with no further write issued; first post-reset cycle behaves as CPU_OWN.

Verification
REQ-021 CPU path: cpu_we=1, addr 0x0010, data 0xBEEF -> next cycle mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF.
REQ-022 Handover: com_req=1, cpu_ack=1 two cycles later -> cpu_stall=1 then com_gnt=1; 3 com_we writes 0x0000..0x0002 -> appear on mem_* one cycle later each, wr_count=3.
REQ-023 Release: com_req=0 in the same cycle as final com_we -> write issued, RELEASE cycle mem_we=0, then cpu_stall=0, com_gnt=0, wr_count holds.
REQ-024 Timeout: TIMEOUT=8, grant then no com_we -> RELEASE after 8 idle cycles, timeout_flag=1; next grant clears it.
REQ-025 Withdrawal: com_req pulses 1 cycle, cpu_ack never high -> back to CPU_OWN, com_gnt stays 0, no mem_we.
REQ-026 Saturation/reset: CNT_W=2, 5 comm writes -> wr_count=3; assert rst_n=0 mid-COM_OWN -> all outputs 0 immediately.
